// File: rtl/psum_wb_pkg.sv
// psum_wb_pkg: state encoding and default geometry shared by the psum writeback block
package psum_wb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wb_state_t;
  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int ADDR_W_DEF  = 11;
endpackage

// File: rtl/wb_valid_pipe.sv
// wb_valid_pipe: LAT-deep valid shift register aligning OFIFO pops with SFP output
module wb_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic din,
  output logic dout
);
  logic [LAT-1:0] sr;
  assign dout = sr[LAT-1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else sr <= flush ? '0 : LAT'({sr, din});
endmodule

// File: rtl/psum_writeback.sv
// psum_writeback: drains OFIFO rows through the SFP into psum SRAM; PSUM_WB_RELU_EN adds a per-job ReLU on written lanes
module psum_writeback
  import psum_wb_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int addr_w  = ADDR_W_DEF,
  parameter int SFP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [addr_w-1:0]      num_out,
  input  logic [addr_w-1:0]      base_addr,
  input  logic                   ofifo_valid,
  output logic                   ofifo_rd,
  input  logic [col*psum_bw-1:0] sfp_in,
`ifdef PSUM_WB_RELU_EN
  input  logic                   relu_en,
`endif
  output logic                   psum_cen,
  output logic                   psum_wen,
  output logic [addr_w-1:0]      psum_a,
  output logic [col*psum_bw-1:0] psum_d,
  output logic                   busy,
  output logic                   done,
  output logic [addr_w-1:0]      wr_count
);
  wb_state_t state, state_nx;
  logic [addr_w-1:0] num_q, base_q, issued, written;
  logic [col*psum_bw-1:0] wr_row;
  logic load, pipe_out, wr;
  wb_valid_pipe #(.LAT(SFP_LAT)) u_pipe (
    .clk  (clk),
    .reset(reset),
    .flush(clear),
    .din  (ofifo_rd),
    .dout (pipe_out)
  );
  assign load     = state == IDLE && start && !clear;
  assign wr       = pipe_out && !clear;
  assign busy     = state == DRAIN || state == FLUSH;
  assign wr_count = written;
`ifdef PSUM_WB_RELU_EN
  logic relu_q;
  for (genvar i = 0; i < col; i++) begin : g_relu
    assign wr_row[i*psum_bw +: psum_bw] =
      (relu_q && sfp_in[i*psum_bw+psum_bw-1]) ? '0 : sfp_in[i*psum_bw +: psum_bw];
  end
`else
  assign wr_row = sfp_in;
`endif
  always_comb begin
    ofifo_rd = state == DRAIN && ofifo_valid && issued < num_q;
    state_nx = clear          ? IDLE
             : state == IDLE  ? (start ? (num_out == '0 ? DONE : DRAIN) : IDLE)
             : state == DRAIN ? ((ofifo_rd && issued + addr_w'(1) == num_q) ? FLUSH : DRAIN)
             : state == FLUSH ? (written == num_q ? DONE : FLUSH)
             : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      num_q    <= '0;
      base_q   <= '0;
      issued   <= '0;
      written  <= '0;
      psum_cen <= 1'b1;
      psum_wen <= 1'b1;
      psum_a   <= '0;
      psum_d   <= '0;
      done     <= 1'b0;
`ifdef PSUM_WB_RELU_EN
      relu_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      done     <= state == DONE && !clear;
      psum_cen <= !wr;
      psum_wen <= !wr;
      if (wr) begin
        psum_a <= base_q + written;
        psum_d <= wr_row;
      end
      if (load) begin
        num_q   <= num_out;
        base_q  <= base_addr;
        issued  <= '0;
        written <= '0;
`ifdef PSUM_WB_RELU_EN
        relu_q  <= relu_en;
`endif
      end else begin
        if (ofifo_rd) issued <= issued + addr_w'(1);
        if (wr) written <= written + addr_w'(1);
      end
    end
endmodule
